uart_tx_ctl: RTL

UART_TX_CTL -- requirements
Module: uart_tx_ctl

---
 rtl/uart_tx_ctl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctl
//  Purpose  : Serial transmitter for register readback frames. An accepted
//             request sends the address byte followed by the data byte
//             (8N1, LSB first). An address of 0x00 sends a single 0x00 sync
//             byte instead.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    clk_freq : system clock frequency in Hz
//    sym_rate : serial bit rate in baud
//  Ports
//    clk      : in  1  system clock, all logic on posedge
//    reset    : in  1  asynchronous, active-low reset
//    tx_addr  : in  8  register address of readback frame
//    tx_dat   : in  8  register data of readback frame
//    tx_req   : in  1  one-cycle request strobe, sampled only when idle
//    TX       : out 1  serial line, idle high, driven from a flop
//    tx_busy  : out 1  high from acceptance to the end of the last stop bit
//    tx_done  : out 1  one-cycle pulse on the cycle tx_busy falls
//  Build option
//    UART_TX_PARITY_EN : when defined, an even parity bit is inserted
//                        between bit 7 and the stop bit (8E1).
// ============================================================================
module uart_tx_ctl #(
    parameter int clk_freq = 3000000,
    parameter int sym_rate = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_dat,
    input  logic       tx_req,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int             SYM_CNT  = clk_freq / sym_rate;
    localparam int             CNT_W    = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    state_t           state,    state_nxt;
    logic [CNT_W-1:0] bit_cnt,  cnt_nxt;
    logic [2:0]       bit_idx,  idx_nxt;
    logic [7:0]       cur_byte, byte_nxt;   // byte currently on the line
    logic [7:0]       dat_q,    dat_nxt;    // data byte waiting behind the address
    logic             pend,     pend_nxt;   // second byte still to be sent
    logic             tx_q,     tx_nxt;
    logic             busy_q,   busy_nxt;
    logic             done_q,   done_nxt;
    logic             bit_end;

    assign bit_end = (bit_cnt == CNT_LAST);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            cur_byte <= '0;
            dat_q    <= '0;
            pend     <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= cnt_nxt;
            bit_idx  <= idx_nxt;
            cur_byte <= byte_nxt;
            dat_q    <= dat_nxt;
            pend     <= pend_nxt;
            tx_q     <= tx_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. The line level for the coming bit is
    // computed here and registered, so TX changes exactly on bit boundaries.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = bit_idx;
        byte_nxt  = cur_byte;
        dat_nxt   = dat_q;
        pend_nxt  = pend;
        tx_nxt    = tx_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                tx_nxt  = 1'b1;
                // The done cycle still belongs to the finished transaction,
                // so a request coinciding with tx_done is dropped.
                if (tx_req && !done_q) begin
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    byte_nxt  = tx_addr;    // 0x00 doubles as the sync byte
                    dat_nxt   = tx_dat;
                    pend_nxt  = (tx_addr != 8'h00);
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = S_DATA;
                    tx_nxt    = cur_byte[0];
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = ^cur_byte;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                        tx_nxt  = cur_byte[idx_nxt];
                    end
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (pend) begin
                        // Data frame follows the address frame with no gap.
                        state_nxt = S_START;
                        tx_nxt    = 1'b0;
                        byte_nxt  = dat_q;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    assign TX      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire
